fp_mul_result_fifo: RTL and testbench

//   Buffers results from the combinational FP32 multiplier. Each entry is {underflow, overflow, product[31:0]}.

---
 rtl/fp_mul_pkg.sv | 29 ++
 rtl/fp_mul_exc_status.sv | 68 ++++++
 rtl/fp_mul_result_fifo.sv | 98 +++++++++
 tb/tb_fp_mul_result_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared FP32 multiplier types: field widths, the buffered result entry, exception counter width.
package fp_mul_pkg;

    localparam int FP32_W    = 32;
    localparam int EXP_W     = 8;
    localparam int MANT_W    = 23;
    localparam int BIAS      = 127;
    localparam int EXC_CNT_W = 16;

    typedef struct packed {
        logic              udf;
        logic              ovf;
        logic [FP32_W-1:0] product;
    } fp_mul_entry_t;

    // Saturating count step; clear dominates so a same-cycle increment is dropped.
    function automatic logic [EXC_CNT_W-1:0] exc_cnt_next(input logic [EXC_CNT_W-1:0] cnt,
                                                         input logic clr,
                                                         input logic inc);
        logic [EXC_CNT_W-1:0] nxt;
        nxt = cnt;
        if (clr)
            nxt = '0;
        else if (inc && (cnt != {EXC_CNT_W{1'b1}}))
            nxt = cnt + EXC_CNT_W'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/fp_mul_exc_status.sv
// Sticky overflow/underflow status for accepted results.
// FPM_EXC_COUNT_EN adds saturating per-flag exception counters.
module fp_mul_exc_status
    import fp_mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic in_ovf,
    input  logic in_udf,
    input  logic clear_sticky,
    output logic sticky_ovf,
    output logic sticky_udf
`ifdef FPM_EXC_COUNT_EN
    ,
    output logic [EXC_CNT_W-1:0] ovf_count,
    output logic [EXC_CNT_W-1:0] udf_count
`endif
);

    logic sticky_ovf_q, sticky_ovf_d;
    logic sticky_udf_q, sticky_udf_d;

    // Set beats clear when a flagged push lands in the clear cycle.
    always_comb begin
        sticky_ovf_d = clear_sticky ? 1'b0 : sticky_ovf_q;
        sticky_udf_d = clear_sticky ? 1'b0 : sticky_udf_q;
        if (push && in_ovf) sticky_ovf_d = 1'b1;
        if (push && in_udf) sticky_udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_q <= 1'b0;
            sticky_udf_q <= 1'b0;
        end else begin
            sticky_ovf_q <= sticky_ovf_d;
            sticky_udf_q <= sticky_udf_d;
        end
    end

    assign sticky_ovf = sticky_ovf_q;
    assign sticky_udf = sticky_udf_q;

`ifdef FPM_EXC_COUNT_EN
    logic [EXC_CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic [EXC_CNT_W-1:0] udf_count_q, udf_count_d;

    always_comb begin
        ovf_count_d = exc_cnt_next(ovf_count_q, clear_sticky, push && in_ovf);
        udf_count_d = exc_cnt_next(udf_count_q, clear_sticky, push && in_udf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
            udf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
            udf_count_q <= udf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
    assign udf_count = udf_count_q;
`endif

endmodule

// File: rtl/fp_mul_result_fifo.sv
// First-word fall-through result FIFO for the FP32 multiplier with sticky exception status.
// FPM_EXC_COUNT_EN exposes ovf_count/udf_count from the status block.
module fp_mul_result_fifo
    import fp_mul_pkg::*;
#(
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_product,
    input  logic              in_overflow,
    input  logic              in_underflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_product,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic [ADDR_W:0]   level,
    output logic              sticky_ovf,
    output logic              sticky_udf,
    input  logic              clear_sticky
`ifdef FPM_EXC_COUNT_EN
    ,
    output logic [EXC_CNT_W-1:0] ovf_count,
    output logic [EXC_CNT_W-1:0] udf_count
`endif
);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    fp_mul_entry_t   mem_q [DEPTH];
    fp_mul_entry_t   mem_d [DEPTH];
    fp_mul_entry_t   head;
    logic            empty, full, push, pop;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = '{udf: in_underflow, ovf: in_overflow, product: in_product};
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible until a push marks it valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head          = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign out_product   = head.product;
    assign out_overflow  = head.ovf;
    assign out_underflow = head.udf;

    fp_mul_exc_status u_exc_status (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .in_ovf       (in_overflow),
        .in_udf       (in_underflow),
        .clear_sticky (clear_sticky),
        .sticky_ovf   (sticky_ovf),
        .sticky_udf   (sticky_udf)
`ifdef FPM_EXC_COUNT_EN
        ,
        .ovf_count    (ovf_count),
        .udf_count    (udf_count)
`endif
    );

endmodule

// File: tb/tb_fp_mul_result_fifo.sv
// Directed self-checking bench for fp_mul_result_fifo; counter tests build with FPM_EXC_COUNT_EN.
module tb_fp_mul_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_product;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        out_overflow;
    logic        out_underflow;
    logic [2:0]  level;
    logic        sticky_ovf;
    logic        sticky_udf;
    logic        clear_sticky;
`ifdef FPM_EXC_COUNT_EN
    logic [15:0] ovf_count;
    logic [15:0] udf_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fp_mul_result_fifo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_product    (in_product),
        .in_overflow   (in_overflow),
        .in_underflow  (in_underflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_product   (out_product),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .level         (level),
        .sticky_ovf    (sticky_ovf),
        .sticky_udf    (sticky_udf),
        .clear_sticky  (clear_sticky)
`ifdef FPM_EXC_COUNT_EN
        ,
        .ovf_count     (ovf_count),
        .udf_count     (udf_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_product = '0; in_overflow = 1'b0; in_underflow = 1'b0;
        out_ready = 1'b0; clear_sticky = 1'b0;
        #12;
        compared++;
        if ({out_valid, level, in_ready, sticky_ovf, sticky_udf} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got valid=%b level=%0d ready=%b sovf=%b sudf=%b, want 0 0 1 0 0",
                     out_valid, level, in_ready, sticky_ovf, sticky_udf);
        end
        compared++;
        if (out_product !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_data: got %h want 00000000", out_product);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_first_word();
        in_valid = 1'b1; in_product = 32'h4040_0000;
        #1;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL no_bypass: got out_valid=%b want 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        compared++;
        if ({out_valid, out_product, level, out_overflow, out_underflow} !== {1'b1, 32'h4040_0000, 3'd1, 2'b00}) begin
            mismatched++;
            $display("FAIL first_word: got valid=%b prod=%h level=%0d flags=%b%b want 1 40400000 1 00",
                     out_valid, out_product, level, out_overflow, out_underflow);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        compared++;
        if ({out_valid, level, out_product} !== {1'b0, 3'd0, 32'h0}) begin
            mismatched++;
            $display("FAIL first_pop: got valid=%b level=%0d prod=%h want 0 0 00000000", out_valid, level, out_product);
        end
    endtask

    task automatic test_full();
        logic [31:0] vals [5] = '{32'h3F80_0000, 32'h4000_0000, 32'hC0A0_0000, 32'h4120_0000, 32'h42C8_0000};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_product = vals[i];
            tick();
        end
        in_product = vals[4];
        #1;
        compared++;
        if ({level, in_ready} !== {3'd4, 1'b0}) begin
            mismatched++;
            $display("FAIL full: got level=%0d in_ready=%b want 4 0", level, in_ready);
        end
        tick();
        compared++;
        if (level !== 3'd4) begin
            mismatched++;
            $display("FAIL full_held: got level=%0d want 4", level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        compared++;
        if ({level, out_product, in_ready} !== {3'd3, vals[1], 1'b1}) begin
            mismatched++;
            $display("FAIL full_pop: got level=%0d head=%h ready=%b want 3 %h 1", level, out_product, in_ready, vals[1]);
        end
        tick();
        in_valid = 1'b0;
        compared++;
        if (level !== 3'd4) begin
            mismatched++;
            $display("FAIL held_accept: got level=%0d want 4", level);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            compared++;
            if (out_product !== vals[i]) begin
                mismatched++;
                $display("FAIL full_order[%0d]: got %h want %h", i, out_product, vals[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        compared++;
        if (level !== 3'd0) begin
            mismatched++;
            $display("FAIL full_drain: got level=%0d want 0", level);
        end
    endtask

    task automatic test_sticky();
        in_valid = 1'b1; in_product = 32'h7F80_0000; in_overflow = 1'b1; in_underflow = 1'b0;
        tick();
        in_product = 32'h0000_0000; in_overflow = 1'b0; in_underflow = 1'b1;
        tick();
        in_valid = 1'b0; in_underflow = 1'b0;
        compared++;
        if ({sticky_ovf, sticky_udf} !== 2'b11) begin
            mismatched++;
            $display("FAIL sticky_set: got ovf=%b udf=%b want 1 1", sticky_ovf, sticky_udf);
        end
        compared++;
        if ({out_product, out_overflow, out_underflow} !== {32'h7F80_0000, 2'b10}) begin
            mismatched++;
            $display("FAIL head_ovf_entry: got %h %b%b want 7f800000 10", out_product, out_overflow, out_underflow);
        end
        out_ready = 1'b1;
        tick();
        compared++;
        if ({out_product, out_overflow, out_underflow} !== {32'h0, 2'b01}) begin
            mismatched++;
            $display("FAIL head_udf_entry: got %h %b%b want 00000000 01", out_product, out_overflow, out_underflow);
        end
        tick();
        out_ready = 1'b0;
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        compared++;
        if ({sticky_ovf, sticky_udf} !== 2'b00) begin
            mismatched++;
            $display("FAIL sticky_clear: got ovf=%b udf=%b want 0 0", sticky_ovf, sticky_udf);
        end
        clear_sticky = 1'b1; in_valid = 1'b1; in_product = 32'h7F80_0000; in_overflow = 1'b1;
        tick();
        clear_sticky = 1'b0; in_valid = 1'b0; in_overflow = 1'b0;
        compared++;
        if ({sticky_ovf, sticky_udf} !== 2'b10) begin
            mismatched++;
            $display("FAIL sticky_set_wins: got ovf=%b udf=%b want 1 0", sticky_ovf, sticky_udf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [$];
        logic [31:0] v;
        for (int i = 0; i < 2; i++) begin
            v = 32'h4100_0000 + 32'(i);
            in_valid = 1'b1; in_product = v; model.push_back(v);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            v = 32'h4100_0000 + 32'(i);
            in_product = v; model.push_back(v);
            compared++;
            if (out_product !== model[0]) begin
                mismatched++;
                $display("FAIL b2b_order[%0d]: got %h want %h", i, out_product, model[0]);
            end
            void'(model.pop_front());
            tick();
            compared++;
            if (level !== 3'd2) begin
                mismatched++;
                $display("FAIL b2b_level[%0d]: got %0d want 2", i, level);
            end
        end
        in_valid = 1'b0;
        while (model.size() > 0) begin
            compared++;
            if (out_product !== model[0]) begin
                mismatched++;
                $display("FAIL b2b_tail: got %h want %h", out_product, model[0]);
            end
            void'(model.pop_front());
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_overflow = 1'b1; in_underflow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_product = 32'hDEAD_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0;
        compared++;
        if ({level, sticky_ovf, sticky_udf} !== {3'd3, 2'b11}) begin
            mismatched++;
            $display("FAIL pre_reset: got level=%0d sticky=%b%b want 3 11", level, sticky_ovf, sticky_udf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({out_valid, level, sticky_ovf, sticky_udf, out_product} !== {1'b0, 3'd0, 2'b00, 32'h0}) begin
            mismatched++;
            $display("FAIL async_reset: got valid=%b level=%0d sticky=%b%b prod=%h want 0 0 00 00000000",
                     out_valid, level, sticky_ovf, sticky_udf, out_product);
        end
        #3;
        rst_n = 1'b1;
        tick();
    endtask

`ifdef FPM_EXC_COUNT_EN
    task automatic test_counters();
        out_ready = 1'b1;
        in_valid = 1'b1; in_product = 32'h7F80_0000; in_overflow = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        compared++;
        if ({ovf_count, udf_count} !== {16'd3, 16'd0}) begin
            mismatched++;
            $display("FAIL ovf_count3: got ovf=%0d udf=%0d want 3 0", ovf_count, udf_count);
        end
        in_valid = 1'b1;
        for (int i = 3; i < 16'hFFFF; i++) tick();
        in_valid = 1'b0;
        compared++;
        if (ovf_count !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL ovf_count_max: got %h want ffff", ovf_count);
        end
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        compared++;
        if (ovf_count !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL ovf_count_sat: got %h want ffff", ovf_count);
        end
        clear_sticky = 1'b1; in_valid = 1'b1;
        tick();
        clear_sticky = 1'b0; in_valid = 1'b0; in_overflow = 1'b0;
        compared++;
        if ({ovf_count, sticky_ovf} !== {16'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL count_clear: got count=%h sticky=%b want 0000 1", ovf_count, sticky_ovf);
        end
        tick();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_first_word();
        test_full();
        test_sticky();
        test_back_to_back();
        test_reset_mid();
`ifdef FPM_EXC_COUNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
